// File: rtl/exec_ctrl.sv
// Execution controller: HALT/RUN/STEP/LOAD sequencing with a tick prescaler.
// Optional breakpoint logic is enabled by defining EXEC_CTRL_BP_EN.
module exec_ctrl #(
    parameter int unsigned TICK_DIV = 12000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    input  logic [3:0] ip,
    output logic       cpu_en,
    output logic       mem_we,
    output logic [3:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic [1:0] state,
`ifdef EXEC_CTRL_BP_EN
    input  logic       bp_valid,
    input  logic [3:0] bp_addr,
    output logic       bp_hit,
`endif
    output logic [7:0] instr_count
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_LOAD = 2'd3
    } state_e;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    localparam logic [23:0] TOP = 24'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic [23:0] presc_q, presc_d;
    logic [23:0] presc_nxt;
    logic        cpu_en_q, cpu_en_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  count_q, count_d;
    logic        bp_hit_q, bp_hit_d;
    logic        accept;
    logic        tick;

    assign cmd_ready = (state_q == S_HALT) || (state_q == S_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign presc_nxt = (presc_q == TOP) ? 24'd0 : presc_q + 24'd1;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cpu_en_d = 1'b0;
        mem_we_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        bp_hit_d = 1'b0;
        tick     = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_HALT: state_d = S_HALT;
                        OP_RUN: begin
                            state_d  = S_RUN;
                            presc_d  = 24'd0;
                            // Period of one: the first pulse lands right after entry.
                            cpu_en_d = (TOP == 24'd0);
                        end
                        OP_STEP: begin
                            state_d  = S_STEP;
                            cpu_en_d = 1'b1;
                        end
                        OP_LOAD: begin
                            state_d  = S_LOAD;
                            mem_we_d = 1'b1;
                            waddr_d  = load_addr;
                            wdata_d  = load_data;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (accept && cmd_op == OP_HALT) begin
                    state_d = S_HALT;
                    presc_d = 24'd0;
                end else begin
                    presc_d  = presc_nxt;
                    tick     = (presc_nxt == TOP);
                    cpu_en_d = tick;
`ifdef EXEC_CTRL_BP_EN
                    if (tick && bp_valid && ip == bp_addr) begin
                        cpu_en_d = 1'b0;
                        state_d  = S_HALT;
                        presc_d  = 24'd0;
                        bp_hit_d = 1'b1;
                    end
`endif
                end
            end
            S_STEP: state_d = S_HALT;
            S_LOAD: state_d = S_HALT;
        endcase
        count_d = count_q + {7'd0, cpu_en_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_HALT;
            presc_q  <= 24'd0;
            cpu_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            waddr_q  <= 4'd0;
            wdata_q  <= 8'd0;
            count_q  <= 8'd0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cpu_en_q <= cpu_en_d;
            mem_we_q <= mem_we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign mem_we      = mem_we_q;
    assign mem_waddr   = waddr_q;
    assign mem_wdata   = wdata_q;
    assign state       = state_q;
    assign instr_count = count_q;

`ifdef EXEC_CTRL_BP_EN
    assign bp_hit = bp_hit_q;
`else
    logic unused_bp;
    assign unused_bp = ^{ip, bp_hit_q, tick};
`endif

endmodule
